// File: rtl/seq_chunk_subtractor_pkg.sv
// Shared types and sizing helpers for the chunked subtractor.
package seq_chunk_subtractor_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int num_chunks(input int n, input int k);
    return (n + k - 1) / k;
  endfunction

  // A single-chunk configuration still needs a one-bit index register.
  function automatic int idx_width(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/seq_chunk_subtractor_if.sv
// Start/done handshake plus operand and result bus of the chunked subtractor.
interface seq_chunk_subtractor_if #(
  parameter int N = 50
);
  logic         start;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         bin;
  logic [N-1:0] diff;
  logic         bout;
  logic         ovf;
  logic         busy;
  logic         done;

  modport master (
    output start, x, y, bin,
    input  diff, bout, ovf, busy, done
  );

  modport slave (
    input  start, x, y, bin,
    output diff, bout, ovf, busy, done
  );
endinterface

// File: rtl/seq_chunk_subtractor_cla.sv
// Combinational K-bit carry-lookahead adder; on the last (possibly narrower)
// chunk the unused upper lanes are masked and cout comes from the top live lane.
module sub_chunk_cla #(
  parameter int K      = 10,
  parameter int LAST_W = 10
) (
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  input  logic         cin,
  input  logic         last,
  output logic [K-1:0] sum,
  output logic         cout
);

  localparam logic [K-1:0] FULL_MASK = {K{1'b1}};
  localparam logic [K-1:0] LAST_MASK = FULL_MASK >> (K - LAST_W);

  logic [K-1:0] mask;
  logic [K-1:0] gm;
  logic [K-1:0] pm;
  logic [K:0]   c;
  logic         run_g;
  logic         run_p;

  assign mask = last ? LAST_MASK : FULL_MASK;
  assign gm   = a & b & mask;
  assign pm   = (a ^ b) & mask;

  // Each carry is the flat sum of products of generate/propagate terms.
  always_comb begin
    c     = '0;
    run_g = 1'b0;
    run_p = 1'b1;
    c[0]  = cin;
    for (int i = 0; i < K; i++) begin
      run_g = 1'b0;
      run_p = 1'b1;
      for (int j = i; j >= 0; j--) begin
        run_g = run_g | (gm[j] & run_p);
        run_p = run_p & pm[j];
      end
      c[i+1] = run_g | (run_p & cin);
    end
  end

  assign sum  = (pm ^ c[K-1:0]) & mask;
  assign cout = last ? c[LAST_W] : c[K];

endmodule

// File: rtl/seq_chunk_subtractor.sv
// Multi-cycle x - y - bin, one K-bit chunk per clock with the borrow kept
// as a registered carry between chunks (x + ~y + ~bin).
module seq_chunk_subtractor
  import seq_chunk_subtractor_pkg::*;
#(
  parameter int N = 50,
  parameter int K = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  seq_chunk_subtractor_if.slave  bus
);

  localparam int M      = num_chunks(N, K);
  localparam int IW     = idx_width(M);
  localparam int PW     = M * K;
  localparam int LAST_W = N - (M - 1) * K;
  localparam logic [IW-1:0] LAST_IDX = IW'(M - 1);

  state_t        state;
  state_t        state_d;
  logic          load;
  logic          step;
  logic          finish;

  logic [IW-1:0] idx;
  logic [PW-1:0] xr;
  logic [PW-1:0] yr;
  logic [PW-1:0] acc;
  logic [PW-1:0] acc_d;
  logic          carry;

  logic [N-1:0]  diff_r;
  logic          bout_r;
  logic          ovf_r;
  logic          done_r;

  logic [K-1:0]  a_chunk;
  logic [K-1:0]  b_chunk;
  logic [K-1:0]  sum_chunk;
  logic          cout;
  logic          last_chunk;

  assign last_chunk = (idx == LAST_IDX);
  assign a_chunk    = xr[idx*K +: K];
  assign b_chunk    = ~yr[idx*K +: K];

  sub_chunk_cla #(
    .K      (K),
    .LAST_W (LAST_W)
  ) u_cla (
    .a    (a_chunk),
    .b    (b_chunk),
    .cin  (carry),
    .last (last_chunk),
    .sum  (sum_chunk),
    .cout (cout)
  );

  // The final diff includes the chunk being computed this cycle.
  always_comb begin
    acc_d              = acc;
    acc_d[idx*K +: K]  = sum_chunk;
  end

  always_comb begin
    state_d = state;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last_chunk) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx    <= '0;
      xr     <= '0;
      yr     <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      diff_r <= '0;
      bout_r <= 1'b0;
      ovf_r  <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= finish;
      if (load) begin
        xr    <= PW'(bus.x);
        yr    <= PW'(bus.y);
        carry <= ~bus.bin;
        idx   <= '0;
        acc   <= '0;
      end else if (step) begin
        carry <= cout;
        acc   <= acc_d;
        idx   <= last_chunk ? '0 : idx + 1'b1;
      end
      // Results are only ever published here, so partial sums stay hidden.
      if (finish) begin
        diff_r <= acc_d[N-1:0];
        bout_r <= ~cout;
        ovf_r  <= (xr[N-1] != yr[N-1]) && (acc_d[N-1] != xr[N-1]);
      end
    end
  end

  assign bus.diff = diff_r;
  assign bus.bout = bout_r;
  assign bus.ovf  = ovf_r;
  assign bus.done = done_r;
  assign bus.busy = (state == RUN);

endmodule

// File: tb/tb_seq_chunk_subtractor.sv
// Self-checking bench: three configurations (K=10, K=16, K=N) against an arithmetic model.
module tb_seq_chunk_subtractor;

  localparam int N  = 50;
  localparam int ND = 3;
  localparam int LAT [ND] = '{5, 4, 1};

  typedef struct {
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         bin;
    logic [N-1:0] diff;
    logic         bout;
    logic         ovf;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_v [ND];
  logic [N-1:0] x_in;
  logic [N-1:0] y_in;
  logic         bin_in;

  logic [N-1:0] obs_diff [ND];
  logic         obs_bout [ND];
  logic         obs_ovf  [ND];
  logic         obs_busy [ND];
  logic         obs_done [ND];

  logic [N-1:0] held_diff [ND];
  logic         held_bout [ND];
  logic         held_ovf  [ND];

  int numChecks = 0;
  int numFails  = 0;
  vec_t vecs [9];

  always #5 clk = ~clk;

  seq_chunk_subtractor_if #(.N(N)) bus10 ();
  seq_chunk_subtractor_if #(.N(N)) bus16 ();
  seq_chunk_subtractor_if #(.N(N)) bus50 ();

  seq_chunk_subtractor #(.N(N), .K(10)) dut10 (.clk(clk), .rst_n(rst_n), .bus(bus10));
  seq_chunk_subtractor #(.N(N), .K(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  seq_chunk_subtractor #(.N(N), .K(N))  dut50 (.clk(clk), .rst_n(rst_n), .bus(bus50));

  assign bus10.start = start_v[0];
  assign bus16.start = start_v[1];
  assign bus50.start = start_v[2];
  assign bus10.x = x_in;  assign bus16.x = x_in;  assign bus50.x = x_in;
  assign bus10.y = y_in;  assign bus16.y = y_in;  assign bus50.y = y_in;
  assign bus10.bin = bin_in;  assign bus16.bin = bin_in;  assign bus50.bin = bin_in;

  assign obs_diff[0] = bus10.diff;  assign obs_diff[1] = bus16.diff;  assign obs_diff[2] = bus50.diff;
  assign obs_bout[0] = bus10.bout;  assign obs_bout[1] = bus16.bout;  assign obs_bout[2] = bus50.bout;
  assign obs_ovf[0]  = bus10.ovf;   assign obs_ovf[1]  = bus16.ovf;   assign obs_ovf[2]  = bus50.ovf;
  assign obs_busy[0] = bus10.busy;  assign obs_busy[1] = bus16.busy;  assign obs_busy[2] = bus50.busy;
  assign obs_done[0] = bus10.done;  assign obs_done[1] = bus16.done;  assign obs_done[2] = bus50.done;

  // Plain integer arithmetic: unsigned compare for borrow, signed range for overflow.
  function automatic vec_t refModel(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
    vec_t   v;
    longint ua, ub, sa, sb, r, lim;
    ua  = longint'({14'b0, a});
    ub  = longint'({14'b0, b});
    lim = longint'(1) << (N - 1);
    sa  = a[N-1] ? ua - (lim << 1) : ua;
    sb  = b[N-1] ? ub - (lim << 1) : ub;
    r   = sa - sb - longint'(c);
    v.x    = a;
    v.y    = b;
    v.bin  = c;
    v.diff = N'(ua - ub - longint'(c));
    v.bout = (ua < ub + longint'(c));
    v.ovf  = (r > lim - 1) || (r < -lim);
    return v;
  endfunction

  function automatic vec_t mkVec(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                                 input logic [N-1:0] d, input logic bo, input logic ov);
    vec_t v;
    v.x = a; v.y = b; v.bin = c; v.diff = d; v.bout = bo; v.ovf = ov;
    return v;
  endfunction

  function automatic logic [N-1:0] rand50();
    return N'({$urandom(), $urandom()});
  endfunction

  task automatic checkOutput(input string name, input int d, input logic [63:0] actual,
                             input logic [63:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s dut%0d: got %0h expected %0h", name, d, actual, expected);
    end
  endtask

  task automatic checkHeld(input int d);
    checkOutput("diff", d, 64'(obs_diff[d]), 64'(held_diff[d]));
    checkOutput("bout", d, 64'(obs_bout[d]), 64'(held_bout[d]));
    checkOutput("ovf",  d, 64'(obs_ovf[d]),  64'(held_ovf[d]));
  endtask

  task automatic clearHeld();
    for (int d = 0; d < ND; d++) begin
      held_diff[d] = '0;
      held_bout[d] = 1'b0;
      held_ovf[d]  = 1'b0;
    end
  endtask

  // Presents operands with start for one edge, then scrambles the inputs.
  task automatic applyStimulus(input logic [ND-1:0] mask, input vec_t v);
    @(negedge clk);
    x_in   = v.x;
    y_in   = v.y;
    bin_in = v.bin;
    for (int d = 0; d < ND; d++) start_v[d] = mask[d];
    @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) start_v[d] = 1'b0;
    x_in   = rand50();
    y_in   = rand50();
    bin_in = 1'($urandom_range(0, 1));
  endtask

  // Checks done/busy timing and that results only change on the done cycle.
  task automatic runOp(input logic [ND-1:0] mask, input vec_t v, input bit poke);
    applyStimulus(mask, v);
    for (int cyc = 0; cyc <= 8; cyc++) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        if (mask[d]) begin
          checkOutput("done", d, 64'(obs_done[d]), 64'(cyc == LAT[d]));
          checkOutput("busy", d, 64'(obs_busy[d]), 64'(cyc < LAT[d]));
          if (cyc == LAT[d]) begin
            held_diff[d] = v.diff;
            held_bout[d] = v.bout;
            held_ovf[d]  = v.ovf;
          end
          checkHeld(d);
        end
      end
      if (poke && cyc == 1) begin
        for (int d = 0; d < ND; d++) start_v[d] = mask[d] && (LAT[d] > 2);
        x_in   = rand50();
        y_in   = rand50();
        bin_in = 1'($urandom_range(0, 1));
      end
      if (poke && cyc == 2) begin
        for (int d = 0; d < ND; d++) start_v[d] = 1'b0;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t va, vb;

    vecs[0] = mkVec(50'd100, 50'd58, 1'b0, 50'd42, 1'b0, 1'b0);
    vecs[1] = mkVec(50'd0, 50'd1, 1'b0, 50'h3_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    vecs[2] = mkVec(50'd1024, 50'd1, 1'b1, 50'd1022, 1'b0, 1'b0);
    vecs[3] = mkVec(50'h1_FFFF_FFFF_FFFF, 50'h3_FFFF_FFFF_FFFF, 1'b0, 50'h2_0000_0000_0000, 1'b1, 1'b1);
    vecs[4] = mkVec(50'h2_0000_0000_0007, 50'h2_0000_0000_0000, 1'b0, 50'd7, 1'b0, 1'b0);
    vecs[5] = mkVec(50'd5, 50'd3, 1'b0, 50'd2, 1'b0, 1'b0);
    vecs[6] = mkVec(50'd0, 50'd0, 1'b1, 50'h3_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    vecs[7] = mkVec(50'h2_0000_0000_0000, 50'd1, 1'b0, 50'h1_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    vecs[8] = mkVec(50'h3_FFFF_FFFF_FFFF, 50'h3_FFFF_FFFF_FFFF, 1'b1, 50'h3_FFFF_FFFF_FFFF, 1'b1, 1'b0);

    rst_n  = 1'b0;
    x_in   = '0;
    y_in   = '0;
    bin_in = 1'b0;
    for (int d = 0; d < ND; d++) start_v[d] = 1'b0;
    clearHeld();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      checkOutput("reset_done", d, 64'(obs_done[d]), 64'd0);
      checkOutput("reset_busy", d, 64'(obs_busy[d]), 64'd0);
      checkHeld(d);
    end
    rst_n = 1'b1;

    $display("[TB] directed vectors");
    for (int i = 0; i < 9; i++) runOp(3'b111, vecs[i], 1'b0);

    $display("[TB] random vectors");
    for (int i = 0; i < 40; i++) begin
      va = refModel(rand50(), rand50(), 1'($urandom_range(0, 1)));
      if (i % 4 == 0) va = refModel(va.x, va.x, va.bin);
      runOp(3'b111, va, 1'b0);
    end

    $display("[TB] start while busy is ignored");
    runOp(3'b011, vecs[4], 1'b1);

    $display("[TB] reset during run");
    applyStimulus(3'b111, refModel(rand50(), rand50(), 1'b1));
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clearHeld();
    for (int cyc = 0; cyc < 6; cyc++) begin
      for (int d = 0; d < ND; d++) begin
        checkOutput("abort_done", d, 64'(obs_done[d]), 64'd0);
        checkOutput("abort_busy", d, 64'(obs_busy[d]), 64'd0);
        checkHeld(d);
      end
      @(negedge clk);
    end
    runOp(3'b111, vecs[5], 1'b0);

    $display("[TB] start held through done on K=16");
    va = vecs[4];
    vb = refModel(rand50(), rand50(), 1'b1);
    @(negedge clk);
    x_in       = va.x;
    y_in       = va.y;
    bin_in     = va.bin;
    start_v[1] = 1'b1;
    @(posedge clk);
    #1;
    x_in   = vb.x;
    y_in   = vb.y;
    bin_in = vb.bin;
    for (int cyc = 0; cyc <= 10; cyc++) begin
      @(negedge clk);
      checkOutput("b2b_done", 1, 64'(obs_done[1]), 64'(cyc == 4 || cyc == 9));
      checkOutput("b2b_busy", 1, 64'(obs_busy[1]), 64'(cyc < 4 || (cyc >= 5 && cyc < 9)));
      if (cyc == 4) begin
        held_diff[1] = va.diff; held_bout[1] = va.bout; held_ovf[1] = va.ovf;
      end
      if (cyc == 9) begin
        held_diff[1] = vb.diff; held_bout[1] = vb.bout; held_ovf[1] = vb.ovf;
      end
      checkHeld(1);
      if (cyc == 5) start_v[1] = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
